// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one combinational multiplier among NUM_REQ requesters.
// It registers the granted operands, holds them for a settle window, and then captures a tagged product.
module n_bit_mul #(
  parameter int BIT_DEPTH = 8
) (
  input  logic [BIT_DEPTH-1:0]   a_i,
  input  logic [BIT_DEPTH-1:0]   b_i,
  output logic [2*BIT_DEPTH-1:0] c_o
);
  logic [2*BIT_DEPTH-1:0] a_ext;
  logic [2*BIT_DEPTH-1:0] b_ext;

  assign a_ext = {{BIT_DEPTH{1'b0}}, a_i};
  assign b_ext = {{BIT_DEPTH{1'b0}}, b_i};
  assign c_o   = a_ext * b_ext;
endmodule

module mul_arbiter #(
  parameter  int BIT_DEPTH   = 8,
  parameter  int NUM_REQ     = 4,
  parameter  int WAIT_CYCLES = 1,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*BIT_DEPTH-1:0]   req_a,
  input  logic [NUM_REQ*BIT_DEPTH-1:0]   req_b,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [2*BIT_DEPTH-1:0]         resp_c,
  output logic [ID_W-1:0]                resp_id,
  output logic                           busy
);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_DEPTH-1:0]   op_a_q, op_a_d;
  logic [BIT_DEPTH-1:0]   op_b_q, op_b_d;
  logic [2*BIT_DEPTH-1:0] resp_c_q, resp_c_d;
  logic [ID_W-1:0]        resp_id_q, resp_id_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [2*BIT_DEPTH-1:0] prod;
  logic [ID_W-1:0]        grant;
  logic                   grant_vld;
  logic [ID_W:0]          search_idx;

  n_bit_mul #(.BIT_DEPTH(BIT_DEPTH)) u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .c_o (prod)
  );

  // First valid requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant      = ptr_q;
    grant_vld  = 1'b0;
    search_idx = {(ID_W+1){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (search_idx >= (ID_W+1)'(NUM_REQ)) begin
        search_idx = search_idx - (ID_W+1)'(NUM_REQ);
      end else begin
        search_idx = search_idx;
      end
      if (!grant_vld && req_valid[search_idx[ID_W-1:0]]) begin
        grant     = search_idx[ID_W-1:0];
        grant_vld = 1'b1;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

  // Sequencer: accept in IDLE, settle in CALC, present the response in DONE
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_c_d     = resp_c_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    req_ready    = {NUM_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
          op_a_d  = req_a[grant*BIT_DEPTH +: BIT_DEPTH];
          op_b_d  = req_b[grant*BIT_DEPTH +: BIT_DEPTH];
          id_d    = grant;
          ptr_d   = (int'(grant) == NUM_REQ - 1) ? {ID_W{1'b0}} : grant + ID_W'(1);
          cnt_d   = {CNT_W{1'b0}};
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      // The operands have been stable for WAIT_CYCLES full cycles after the load edge when cnt reaches WAIT_CYCLES
      CALC: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
          resp_c_d     = prod;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= {ID_W{1'b0}};
      id_q         <= {ID_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      op_a_q       <= {BIT_DEPTH{1'b0}};
      op_b_q       <= {BIT_DEPTH{1'b0}};
      resp_c_q     <= {(2*BIT_DEPTH){1'b0}};
      resp_id_q    <= {ID_W{1'b0}};
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_c_q     <= resp_c_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_c     = resp_c_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);
endmodule
